sync_filter: RTL

Parametrised multi-channel input conditioner. It replaces single reset-to-zero flops on asynchronous inputs (UART RX line, switches, external strobes) with three pieces per channel: a configurable synchronizer chain, a glitch/debounce filter and edge-pulse generation. It sits at the top-level pad boundary, ahead of the UART receiver and control logic.

---
 rtl/sync_filter.sv | 73 +++++++
 1 files changed

// File: rtl/sync_filter.sv
// Multi-channel pad-boundary input conditioner: per-channel synchronizer chain,
// debounce filter and registered rise/fall pulses on the filtered level.
module sync_filter #(
  parameter int                  CHANNELS    = 4,
  parameter int                  SYNC_STAGES = 2,
  parameter int                  FILTER_CNT  = 4,
  parameter logic [CHANNELS-1:0] RESET_VAL   = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [CHANNELS-1:0] din,
  output logic [CHANNELS-1:0] sync_out,
  output logic [CHANNELS-1:0] dout,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall
);

  localparam int            CW       = $clog2(FILTER_CNT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CNT - 1);

  generate
    if (CHANNELS < 1 || SYNC_STAGES < 2 || FILTER_CNT < 1) begin : g_param_check
      $error("sync_filter: CHANNELS>=1, SYNC_STAGES>=2 and FILTER_CNT>=1 are required");
    end
  endgenerate

  logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
  logic [CW-1:0]       cnt    [CHANNELS];

  // Synchronizer chain runs every clock; en only qualifies the filter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: every stage is reset to RESET_VAL so release cannot look like an edge on the line.
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= RESET_VAL;
    end else begin
      // NOTE: non-blocking assignments let the loop shift the whole chain by exactly one stage.
      sync_q[0] <= din;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

  // A channel is PENDING while sync_out differs from dout; the counter tracks
  // qualified samples of the new level and dout flips on the last one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout <= RESET_VAL;
      rise <= '0;
      fall <= '0;
      for (int i = 0; i < CHANNELS; i++) cnt[i] <= '0;
    end else begin
      rise <= '0;
      fall <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        if (sync_out[i] == dout[i]) begin
          cnt[i] <= '0;
        end else if (en) begin
          if (cnt[i] == CNT_LAST) begin
            dout[i] <= sync_out[i];
            rise[i] <= sync_out[i];
            fall[i] <= ~sync_out[i];
            cnt[i]  <= '0;
          end else begin
            cnt[i] <= cnt[i] + 1'b1;
          end
        end
      end
    end
  end

endmodule
